// File: rtl/tsc_fetch_unit.sv
// TSC instruction-fetch front end: prefetch FIFO, sequential PC generation
// and redirect with flush, feeding {pc, instruction} to decode over valid/ready.
module tsc_fetch_unit #(
    parameter int                  WORD_SIZE = 16,
    parameter int                  DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 readM,
    output logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [WORD_SIZE-1:0] inst_data,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic [WORD_SIZE-1:0] num_fetched,
    output logic [WORD_SIZE-1:0] num_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] fifo_pc   [DEPTH];
    logic [WORD_SIZE-1:0] fifo_data [DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_after;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 drop;

    // Handshake events for this cycle; redirect suppresses push and pop
    always_comb begin
        empty       = (count == '0);
        push        = (state == REQ) && inputReady && !redirect_valid;
        pop         = !empty && inst_ready && !redirect_valid;
        drop        = inputReady &&
                      ((state == DROP) || ((state == REQ) && redirect_valid));
        count_after = count + CW'(push) - CW'(pop);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: one outstanding request, DROP absorbs a stale return
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && (count < CW'(DEPTH)))
                    state_nxt = REQ;
            end
            REQ: begin
                if (redirect_valid)
                    state_nxt = inputReady ? REQ : DROP;
                else if (inputReady)
                    state_nxt = (count_after < CW'(DEPTH)) ? REQ : IDLE;
            end
            DROP: begin
                if (inputReady) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: memory request and FIFO head (zero when empty)
    always_comb begin
        readM      = (state != IDLE);
        address    = req_addr;
        inst_valid = !empty;
        inst_data  = empty ? '0 : fifo_data[rd_ptr];
        inst_pc    = empty ? '0 : fifo_pc[rd_ptr];
    end

    // Fetch PC and request address tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc;
            else if (push)
                fetch_pc <= fetch_pc + WORD_SIZE'(1);
            unique case (state)
                IDLE: begin
                    if (state_nxt == REQ) req_addr <= fetch_pc;
                end
                REQ: begin
                    if (inputReady && (state_nxt == REQ))
                        req_addr <= redirect_valid ? redirect_pc
                                                   : fetch_pc + WORD_SIZE'(1);
                end
                DROP: begin
                    if (inputReady)
                        req_addr <= redirect_valid ? redirect_pc : fetch_pc;
                end
                default: req_addr <= req_addr;
            endcase
        end
    end

    // FIFO pointers and occupancy; redirect flushes everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_after;
        end
    end

    // FIFO storage; contents are masked by count so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= req_addr;
            fifo_data[wr_ptr] <= data;
        end
    end

    // Statistics counters, wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_fetched <= '0;
            num_dropped <= '0;
        end else begin
            if (push) num_fetched <= num_fetched + WORD_SIZE'(1);
            if (drop) num_dropped <= num_dropped + WORD_SIZE'(1);
        end
    end

endmodule
